// File: rtl/pc_seq_if.sv
// Sequencer control/status bundle: instruction-decode inputs, branch-table lookup, fetch status.
interface pc_seq_if #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
);
  logic                    start;
  logic                    stall;
  logic                    done_in;
  logic                    branch_rel;
  logic                    branch_abs;
  logic [4:0]              br_idx;
  logic [4:0]              lut_ptr;
  logic signed [PC_W-1:0]  target;
  logic [PC_W-1:0]         pc;
  logic                    fetch_valid;
  logic                    halted;
  logic [7:0]              br_count;
  logic [CNT_W-1:0]        cycle_count;

  modport master (
    output start, stall, done_in, branch_rel, branch_abs, br_idx, target,
    input  lut_ptr, pc, fetch_valid, halted, br_count, cycle_count
  );

  modport slave (
    input  start, stall, done_in, branch_rel, branch_abs, br_idx, target,
    output lut_ptr, pc, fetch_valid, halted, br_count, cycle_count
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/BRANCH/HALT with a one-bubble branch redirect
// through an external branch-target table, plus saturating branch and cycle counters.
module pc_sequencer #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic     CLK,
  input  logic     reset_n,
  pc_seq_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_BRANCH, S_HALT} state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [4:0]       lut_ptr_q, lut_ptr_d;
  logic             abs_q, abs_d;
  logic [7:0]       br_count_q, br_count_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic             fetch_valid_q, fetch_valid_d;
  logic             halted_q, halted_d;

  logic [CNT_W-1:0] cyc_inc;
  logic [7:0]       br_inc;

  assign cyc_inc = (&cycle_count_q) ? cycle_count_q : cycle_count_q + CNT_W'(1);
  assign br_inc  = (&br_count_q)    ? br_count_q    : br_count_q + 8'd1;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    lut_ptr_d     = lut_ptr_q;
    abs_d         = abs_q;
    br_count_d    = br_count_q;
    cycle_count_d = cycle_count_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (bus.start) begin
          state_d       = S_RUN;
          pc_d          = '0;
          lut_ptr_d     = '0;
          br_count_d    = '0;
          cycle_count_d = '0;
        end
      end
      S_RUN: begin
        cycle_count_d = cyc_inc;
        if (bus.done_in) begin
          state_d = S_HALT;
        end else if (bus.stall) begin
          state_d = S_RUN;
        end else if (bus.branch_rel || bus.branch_abs) begin
          // Absolute wins when both flags are set
          state_d   = S_BRANCH;
          lut_ptr_d = bus.br_idx;
          abs_d     = bus.branch_abs;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      S_BRANCH: begin
        cycle_count_d = cyc_inc;
        if (!bus.stall) begin
          state_d    = S_RUN;
          pc_d       = abs_q ? PC_W'(bus.target) : pc_q + PC_W'(bus.target);
          br_count_d = br_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase
    fetch_valid_d = (state_d == S_RUN);
    halted_d      = (state_d == S_HALT);
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      lut_ptr_q     <= '0;
      abs_q         <= 1'b0;
      br_count_q    <= '0;
      cycle_count_q <= '0;
      fetch_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      lut_ptr_q     <= lut_ptr_d;
      abs_q         <= abs_d;
      br_count_q    <= br_count_d;
      cycle_count_q <= cycle_count_d;
      fetch_valid_q <= fetch_valid_d;
      halted_q      <= halted_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.lut_ptr     = lut_ptr_q;
  assign bus.br_count    = br_count_q;
  assign bus.cycle_count = cycle_count_q;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.halted      = halted_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Vector-table and scoreboard bench for pc_sequencer with a model branch-target table.
module tb_pc_sequencer;
  logic CLK = 1'b0;
  logic reset_n = 1'b0;
  always #5 CLK = ~CLK;

  pc_seq_if #(.PC_W(8), .CNT_W(16)) bus ();
  pc_sequencer #(.PC_W(8), .CNT_W(16)) dut (.CLK(CLK), .reset_n(reset_n), .bus(bus));

  logic [7:0] lut [32];
  assign bus.target = lut[bus.lut_ptr];

  typedef struct {
    logic       start, stall, done_in, rel, abs;
    logic [4:0] idx;
    logic [7:0] pc;
    logic       fv, h;
    logic [7:0] bc;
    logic [15:0] cc;
    logic [4:0] lp;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  function automatic vec_t mk(input logic st, sl, dn, rl, ab, input logic [4:0] idx,
                              input logic [7:0] pc, input logic fv, h, input logic [7:0] bc,
                              input logic [15:0] cc, input logic [4:0] lp);
    vec_t v;
    v.start = st; v.stall = sl; v.done_in = dn; v.rel = rl; v.abs = ab; v.idx = idx;
    v.pc = pc; v.fv = fv; v.h = h; v.bc = bc; v.cc = cc; v.lp = lp;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input vec_t e);
    chk({tag, " pc"},          int'(bus.pc),          int'(e.pc));
    chk({tag, " fetch_valid"}, int'(bus.fetch_valid), int'(e.fv));
    chk({tag, " halted"},      int'(bus.halted),      int'(e.h));
    chk({tag, " br_count"},    int'(bus.br_count),    int'(e.bc));
    chk({tag, " cycle_count"}, int'(bus.cycle_count), int'(e.cc));
    chk({tag, " lut_ptr"},     int'(bus.lut_ptr),     int'(e.lp));
  endtask

  // Drive on the falling edge, score the result just after the next rising edge.
  task automatic step(input vec_t v, input string tag);
    vec_t e;
    @(negedge CLK);
    bus.start = v.start; bus.stall = v.stall; bus.done_in = v.done_in;
    bus.branch_rel = v.rel; bus.branch_abs = v.abs; bus.br_idx = v.idx;
    sb.push_back(v);
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      chk({tag, " scoreboard empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk_out(tag, e);
    end
  endtask

  initial begin
    vec_t z;
    for (int i = 0; i < 32; i++) lut[i] = 8'h00;
    lut[1] = 8'hF5;  // -11
    lut[2] = 8'd15;
    lut[3] = 8'd5;
    lut[4] = 8'hFE;  // -2
    lut[5] = 8'h10;
    lut[7] = 8'h77;
    bus.start = 0; bus.stall = 0; bus.done_in = 0;
    bus.branch_rel = 0; bus.branch_abs = 0; bus.br_idx = '0;

    //            st sl dn rl ab idx   pc   fv h  bc  cc  lp
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0,   1, 0, 0,  0,  0));
    for (int i = 1; i <= 10; i++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'(i), 1, 0, 0, 16'(i), 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1,  10,  0, 0, 0,  11, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  255, 1, 0, 1,  12, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0,   1, 0, 1,  13, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  1,   1, 0, 1,  14, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  2,   1, 0, 1,  15, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  3,   1, 0, 1,  16, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 2,  3,   0, 0, 1,  17, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  15,  1, 0, 2,  18, 2));
    tbl.push_back(mk(0, 0, 0, 1, 1, 3,  15,  0, 0, 2,  19, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  5,   1, 0, 3,  20, 3));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 1, 0, 1, 0, 4, 5, 1, 0, 3, 16'(21 + i), 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  6,   1, 0, 3,  24, 3));
    tbl.push_back(mk(0, 0, 0, 1, 0, 4,  6,   0, 0, 3,  25, 4));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 1, 0, 0, 1, 7, 6, 0, 0, 3, 16'(26 + i), 4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  4,   1, 0, 4,  29, 4));
    tbl.push_back(mk(0, 1, 1, 1, 0, 9,  4,   0, 1, 4,  30, 4));
    tbl.push_back(mk(0, 0, 1, 1, 1, 9,  4,   0, 1, 4,  30, 4));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0,   1, 0, 0,  0,  0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  1,   1, 0, 0,  1,  0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  2,   1, 0, 0,  2,  0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1,  2,   0, 0, 0,  3,  1));

    z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk_out("reset", z);
    @(negedge CLK);
    reset_n = 1'b1;
    step(z, "idle_hold");

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i], $sformatf("vec%0d", i));

    // Now sitting in BRANCH with a pending redirect; drop reset between edges.
    #2;
    reset_n = 1'b0;
    #1;
    chk_out("async_reset", z);
    @(negedge CLK);
    bus.branch_rel = 0;
    reset_n = 1'b1;
    step(z, "post_reset");

    step(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), "restart");
    for (int i = 0; i < 256; i++) begin
      step(mk(0, 0, 0, 0, 1, 5, (i == 0) ? 8'h00 : 8'h10, 0, 0,
              (i > 255) ? 8'd255 : 8'(i), 16'(2 * i + 1), 5), $sformatf("sat_br%0d", i));
      step(mk(0, 0, 0, 0, 0, 0, 8'h10, 1, 0,
              (i + 1 > 255) ? 8'd255 : 8'(i + 1), 16'(2 * i + 2), 5), $sformatf("sat_run%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 8, program counter width in bits.
REQ-002 SHALL have parameter CNT_W, default 16, cycle-counter width in bits.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  launch execution from PC=0 (honoured in IDLE/HALT only).
REQ-006 stall  input  1  hold all sequencing state this cycle.
REQ-007 done_in  input  1  current instruction is halt.
REQ-008 branch_rel  input  1  current instruction is a taken relative branch.
REQ-009 branch_abs  input  1  current instruction is an absolute jump.
REQ-010 br_idx  input  5  branch-table index from the instruction field.
REQ-011 lut_ptr  output  5  registered index driven to the branch-target lookup table.
REQ-012 target  input  PC_W signed  lookup-table result for lut_ptr (combinational path from lut_ptr).
REQ-013 pc  output  PC_W  current fetch address.
REQ-014 fetch_valid  output  1  pc addresses a valid instruction this cycle.
REQ-015 halted  output  1  sequencer is in HALT.
REQ-016 br_count  output  8  taken branches/jumps since start, saturating at 255.
REQ-017 cycle_count  output  CNT_W  cycles spent in RUN/BRANCH since start, saturating at all-ones.

Function
REQ-018 SHALL implement states IDLE, RUN, BRANCH, HALT.
REQ-019 IDLE: start=1 -> RUN, pc=0, counters cleared; otherwise hold; fetch_valid=0.
REQ-020 RUN, priority done_in > stall > branch_rel/branch_abs > sequential.
REQ-021 RUN, done_in=1 -> HALT, pc held.
REQ-022 RUN, stall=1 (done_in=0) -> stay RUN, pc, lut_ptr, br_count held.
REQ-023 RUN, branch_rel or branch_abs -> BRANCH; lut_ptr<=br_idx; mode latched (abs wins if both); pc held.
REQ-024 RUN, no event -> pc<=pc+1, modulo 2^PC_W.
REQ-025 fetch_valid=1 in RUN, 0 in IDLE, BRANCH, HALT.
REQ-026 BRANCH, stall=0 -> RUN; relative: pc<=pc+target (two's complement, modulo 2^PC_W); absolute: pc<=target as unsigned; br_count increments.
REQ-027 BRANCH, stall=1 -> remain BRANCH, no update.
REQ-028 Branch latency: one bubble cycle; redirected pc is valid 2 cycles after the branch instruction was presented.
REQ-029 done_in, branch inputs ignored outside RUN; start ignored in RUN/BRANCH.
REQ-030 HALT: halted=1; start=1 -> RUN, pc=0, lut_ptr=0, counters cleared.
REQ-031 cycle_count increments every cycle in RUN or BRANCH, stalled or not; saturates.
REQ-032 br_count saturates at 255, never wraps.
REQ-033 lut_ptr changes only on branch entry or restart.

Reset
REQ-034 reset_n=0 SHALL immediately force state=IDLE, pc=0, lut_ptr=0, br_count=0, cycle_count=0, fetch_valid=0, halted=0, independent of CLK.
REQ-035 Reset asserted mid-BRANCH SHALL abandon the pending redirect; no partial pc update.
REQ-036 First state change after reset_n rises SHALL be on a later rising CLK edge.

Verification
REQ-037 Reset, start pulse, 5 idle cycles -> pc 0,1,2,3,4,5; fetch_valid=1 from first RUN cycle; cycle_count=5.
REQ-038 At pc=10, branch_rel, br_idx=1, target=-11 -> one bubble (fetch_valid=0), then pc=255 (wrap), br_count=1.
REQ-039 At pc=3, branch_abs, target=15 -> pc=15 after bubble; branch_rel+branch_abs together -> absolute taken.
REQ-040 stall held 3 cycles in RUN and in BRANCH -> pc, lut_ptr unchanged; cycle_count still increments; redirect applied on first unstalled cycle.
REQ-041 done_in with stall and branch_rel together -> HALT, halted=1, pc held; later start -> pc=0, counters 0.
REQ-042 reset_n low between CLK edges during BRANCH -> outputs at reset values immediately; 256 branches -> br_count=255.
